// File: rtl/risc_pkg.sv
// Shared types for the memory arbiter: access sizes, FSM states, owners and timeout default.
// mem_size_t is the same encoding the core control path uses for load/store width.
package risc_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_t;

  localparam int MEM_TIMEOUT_CYCLES = 255;

  // Byte accesses are always aligned; halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lsb);
    case (size)
      HALF_WORD: return addr_lsb[0];
      WORD:      return |addr_lsb;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Shared memory port: one request/grant handshake plus a response strobe that also acks stores.
// The arbiter drives through the master modport, the memory model/controller uses slave.
interface mem_arbiter_if;
  import risc_pkg::*;

  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr_en;
  mem_size_t   size;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, wdata, wr_en, size,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, wdata, wr_en, size,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port, data first, one transaction in flight.
// Done is combinational on rvalid (2 cycles min); misaligned data and timeouts complete with err.
module mem_arbiter
  import risc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          dm_req,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  input  logic          dm_wr_en,
  input  mem_size_t     dm_size,
  output logic          dm_done,
  output logic [31:0]   dm_rdata,
  output logic          dm_err,
  mem_arbiter_if.master mem,
  output logic          stall
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_en_q, wr_en_d;
  mem_size_t   size_q, size_d;

  logic        done;
  logic        err;
  logic [31:0] rdata;
  arb_owner_t  done_for;
  logic        timeout;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_en_d  = wr_en_q;
    size_d   = size_q;
    done     = 1'b0;
    err      = 1'b0;
    rdata    = '0;
    done_for = owner_q;
    timeout  = (state_q != IDLE) && (cnt_q == TIMEOUT_LAST);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dm_req) begin
          if (is_misaligned(dm_size, dm_addr[1:0])) begin
            done     = 1'b1;
            err      = 1'b1;
            done_for = DATA;
          end else begin
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            wr_en_d = dm_wr_en;
            size_d  = dm_size;
            owner_d = DATA;
            state_d = REQ;
          end
        end else if (if_req) begin
          addr_d  = if_addr;
          wr_en_d = 1'b0;
          size_d  = WORD;
          owner_d = FETCH;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout) begin
          done    = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end else if (mem.gnt) begin
          state_d = RSP;
        end
      end
      RSP: begin
        cnt_d = cnt_q + 8'd1;
        // A response landing on the last allowed cycle still counts as a success.
        if (mem.rvalid) begin
          done    = 1'b1;
          rdata   = mem.rdata;
          state_d = IDLE;
        end else if (timeout) begin
          done    = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      done  = 1'b0;
      err   = 1'b0;
      rdata = '0;
    end

    if_done  = done && (done_for == FETCH);
    if_err   = if_done && err;
    if_rdata = if_done ? rdata : '0;
    dm_done  = done && (done_for == DATA);
    dm_err   = dm_done && err;
    dm_rdata = dm_done ? rdata : '0;
  end

  // Request is withdrawn on the abort cycle so memory cannot accept an orphaned access.
  assign mem.req   = (state_q == REQ) && !timeout && !reset;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign mem.wr_en = wr_en_q;
  assign mem.size  = size_q;

  assign stall = (if_req & ~if_done) | (dm_req & ~dm_done);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= FETCH;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      size_q  <= WORD;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      size_q  <= size_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, hand-written timeout/reset sequences and random traffic.
// Expected completion cycles come from transaction-level arithmetic on grant/response delays.
module tb_mem_arbiter;
  import risc_pkg::*;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_wr_en;
  mem_size_t   dm_size;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        stall;

  mem_arbiter_if mem_bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .dm_req   (dm_req),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_wr_en (dm_wr_en),
    .dm_size  (dm_size),
    .dm_done  (dm_done),
    .dm_rdata (dm_rdata),
    .dm_err   (dm_err),
    .mem      (mem_bus),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit          do_if;
    bit          do_dm;
    bit          dm_wr;
    mem_size_t   dm_sz;
    logic [31:0] dm_a;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;
    logic [31:0] if_a;
    logic [31:0] if_rd;
    int          dm_g;
    int          dm_r;
    int          if_g;
    int          if_r;
    int          exp_dm_len;
    bit          exp_dm_err;
    int          exp_if_len;
    bit          exp_if_err;
  } case_t;

  function automatic case_t mk(bit di, bit dd, bit wr, mem_size_t sz, logic [31:0] da,
                               logic [31:0] dwd, logic [31:0] drd, logic [31:0] ia,
                               logic [31:0] ird, int dg, int dr, int ig, int ir,
                               int edl, bit ede, int eil, bit eie);
    case_t t;
    t.do_if = di; t.do_dm = dd; t.dm_wr = wr; t.dm_sz = sz;
    t.dm_a = da; t.dm_wd = dwd; t.dm_rd = drd; t.if_a = ia; t.if_rd = ird;
    t.dm_g = dg; t.dm_r = dr; t.if_g = ig; t.if_r = ir;
    t.exp_dm_len = edl; t.exp_dm_err = ede; t.exp_if_len = eil; t.exp_if_err = eie;
    return t;
  endfunction

  // Reference: a transaction lasts 2+g+r cycles from its IDLE decision, capped at TIMEOUT.
  function automatic void txn_outcome(input int g, input int r, output int len, output bit err);
    if (2 + g + r <= TIMEOUT) begin
      len = 2 + g + r;
      err = 1'b0;
    end else begin
      len = TIMEOUT;
      err = 1'b1;
    end
  endfunction

  function automatic case_t predict(input case_t t);
    case_t o;
    int nbytes;
    o = t;
    nbytes = (t.dm_sz == BYTE) ? 1 : (t.dm_sz == HALF_WORD) ? 2 : 4;
    o.exp_dm_len = 0; o.exp_dm_err = 1'b0; o.exp_if_len = 0; o.exp_if_err = 1'b0;
    if (t.do_dm) begin
      if ((t.dm_a % nbytes) != 0) begin
        o.exp_dm_len = 0;
        o.exp_dm_err = 1'b1;
      end else begin
        txn_outcome(t.dm_g, t.dm_r, o.exp_dm_len, o.exp_dm_err);
      end
    end
    if (t.do_if) txn_outcome(t.if_g, t.if_r, o.exp_if_len, o.exp_if_err);
    return o;
  endfunction

  // Plays one case cycle by cycle; entry and exit are just after a falling edge.
  task automatic run_case(input case_t tc, input string tag);
    int  if_start, if_end, total, t_start, len, g, r, off;
    bit  cur_dm, e_if_done, e_dm_done, e_mreq, e_err;
    if_start = tc.do_dm ? tc.exp_dm_len + 1 : 0;
    if_end   = if_start + tc.exp_if_len;
    total    = tc.do_if ? if_end : tc.exp_dm_len;
    for (int c = 0; c <= total; c++) begin
      cur_dm  = tc.do_dm && (c <= tc.exp_dm_len);
      t_start = cur_dm ? 0 : if_start;
      len     = cur_dm ? tc.exp_dm_len : tc.exp_if_len;
      g       = cur_dm ? tc.dm_g : tc.if_g;
      r       = cur_dm ? tc.dm_r : tc.if_r;
      off     = c - t_start;

      if_req   = tc.do_if && (c <= if_end);
      if_addr  = tc.if_a;
      dm_req   = tc.do_dm && (c <= tc.exp_dm_len);
      dm_addr  = tc.dm_a;
      dm_wdata = tc.dm_wd;
      dm_wr_en = tc.dm_wr;
      dm_size  = tc.dm_sz;
      mem_bus.gnt    = (off == 1 + g) && (off <= len);
      mem_bus.rvalid = (off == 2 + g + r) && (off <= len);
      mem_bus.rdata  = mem_bus.rvalid ? (cur_dm ? tc.dm_rd : tc.if_rd) : $urandom();

      e_if_done = tc.do_if && (c == if_end);
      e_dm_done = tc.do_dm && (c == tc.exp_dm_len);
      e_mreq    = (off >= 1) && (off <= 1 + g) && (off < len);
      #1;
      check({tag, " if_done"}, 32'(if_done), 32'(e_if_done));
      check({tag, " dm_done"}, 32'(dm_done), 32'(e_dm_done));
      check({tag, " mem_req"}, 32'(mem_bus.req), 32'(e_mreq));
      check({tag, " stall"}, 32'(stall),
            32'((if_req && !e_if_done) || (dm_req && !e_dm_done)));
      if (e_if_done) begin
        e_err = tc.exp_if_err;
        check({tag, " if_err"}, 32'(if_err), 32'(e_err));
        check({tag, " if_rdata"}, if_rdata, e_err ? 32'h0 : tc.if_rd);
      end
      if (e_dm_done) begin
        e_err = tc.exp_dm_err;
        check({tag, " dm_err"}, 32'(dm_err), 32'(e_err));
        if (tc.exp_dm_len != 0) check({tag, " dm_rdata"}, dm_rdata, e_err ? 32'h0 : tc.dm_rd);
      end
      if (e_mreq) begin
        check({tag, " mem_addr"}, mem_bus.addr, cur_dm ? tc.dm_a : tc.if_a);
        check({tag, " mem_wr_en"}, 32'(mem_bus.wr_en), cur_dm ? 32'(tc.dm_wr) : 32'h0);
        check({tag, " mem_size"}, 32'(mem_bus.size), cur_dm ? 32'(tc.dm_sz) : 32'(WORD));
        if (cur_dm) check({tag, " mem_wdata"}, mem_bus.wdata, tc.dm_wd);
      end
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0; mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " if_done"}, 32'(if_done), 32'h0);
    check({tag, " dm_done"}, 32'(dm_done), 32'h0);
    check({tag, " errs"}, 32'({if_err, dm_err}), 32'h0);
    check({tag, " if_rdata"}, if_rdata, 32'h0);
    check({tag, " dm_rdata"}, dm_rdata, 32'h0);
    check({tag, " mem_req"}, 32'(mem_bus.req), 32'h0);
    check({tag, " mem_wr_en"}, 32'(mem_bus.wr_en), 32'h0);
    check({tag, " mem_addr"}, mem_bus.addr, 32'h0);
    check({tag, " mem_wdata"}, mem_bus.wdata, 32'h0);
    check({tag, " mem_size"}, 32'(mem_bus.size), 32'(WORD));
  endtask

  case_t table_v[11];

  initial begin
    case_t tc;
    int    sel;

    table_v[0]  = mk(1, 0, 0, WORD, 0, 0, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 2, 0);
    table_v[1]  = mk(0, 1, 0, WORD, 32'h40, 0, 32'hCAFEF00D, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0);
    table_v[2]  = mk(0, 1, 1, BYTE, 32'h203, 32'hA5, 32'h5A, 0, 0, 0, 2, 0, 0, 4, 0, 0, 0);
    table_v[3]  = mk(0, 1, 0, HALF_WORD, 32'h203, 0, 32'h1111, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    table_v[4]  = mk(0, 1, 1, WORD, 32'h202, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    table_v[5]  = mk(0, 1, 0, HALF_WORD, 32'h202, 0, 32'hBEEF, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    table_v[6]  = mk(1, 0, 0, WORD, 0, 0, 0, 32'h104, 32'h1, 0, 0, 3, 0, 0, 0, 4, 1);
    table_v[7]  = mk(0, 1, 0, WORD, 32'h48, 0, 32'h77, 0, 0, 1, 2, 0, 0, 4, 1, 0, 0);
    table_v[8]  = mk(1, 1, 1, WORD, 32'h200, 32'h12345678, 32'h0, 32'h108, 32'h13579BDF,
                     0, 0, 0, 0, 2, 0, 2, 0);
    table_v[9]  = mk(1, 1, 0, WORD, 32'h201, 0, 0, 32'h10C, 32'h2468ACE0, 0, 0, 1, 1, 0, 1, 4, 0);
    table_v[10] = mk(1, 1, 0, BYTE, 32'h3, 0, 32'hFF, 32'h110, 32'h42, 0, 1, 2, 1, 3, 0, 4, 1);

    reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_addr = '0;
    dm_wdata = '0; dm_wr_en = 1'b0; dm_size = WORD;
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    #1;
    check_reset_outputs("post_reset");
    check("post_reset stall", 32'(stall), 32'h0);
    tick();

    for (int i = 0; i < 11; i++) run_case(table_v[i], $sformatf("vec%0d", i));

    // Timeout with the response arriving one cycle too late.
    tc = mk(1, 0, 0, WORD, 0, 0, 0, 32'h300, 32'hABCD, 0, 0, 0, 5, 0, 0, 0, 0);
    tc = predict(tc);
    run_case(tc, "late");
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'hABCD;
    #1;
    check("late if_done", 32'(if_done), 32'h0);
    check("late dm_done", 32'(dm_done), 32'h0);
    check("late mem_req", 32'(mem_bus.req), 32'h0);
    tick();
    mem_bus.rvalid = 1'b0;

    // Reset while the fetch sits in RSP; the trailing response must vanish.
    if_req = 1'b1; if_addr = 32'h400;
    tick();
    mem_bus.gnt = 1'b1;
    #1;
    check("rst_rsp mem_req", 32'(mem_bus.req), 32'h1);
    tick();
    mem_bus.gnt = 1'b0; reset = 1'b1; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h99;
    #1;
    check("rst_rsp if_done_in_reset", 32'(if_done), 32'h0);
    tick();
    reset = 1'b0; if_req = 1'b0;
    #1;
    check_reset_outputs("rst_rsp");
    check("rst_rsp stall", 32'(stall), 32'h0);
    tick();
    mem_bus.rvalid = 1'b0;
    #1;
    check("rst_rsp idle mem_req", 32'(mem_bus.req), 32'h0);
    tick();

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 2);
      tc.do_if = (sel != 1);
      tc.do_dm = (sel != 0);
      tc.dm_wr = 1'($urandom_range(0, 1));
      tc.dm_sz = mem_size_t'(2'($urandom_range(0, 2)));
      tc.dm_a  = $urandom();
      tc.dm_wd = $urandom();
      tc.dm_rd = $urandom();
      tc.if_a  = $urandom() & 32'hFFFF_FFFC;
      tc.if_rd = $urandom();
      tc.dm_g  = $urandom_range(0, 3);
      tc.dm_r  = $urandom_range(0, 3);
      tc.if_g  = $urandom_range(0, 3);
      tc.if_r  = $urandom_range(0, 3);
      tc = predict(tc);
      run_case(tc, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
